// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Multi-cycle data-memory responder for the RISC-V pipeline.
//                Accepts one load/store at a time over a valid/ready
//                handshake, applies RV32 byte/half/word semantics from
//                funct3 and answers after LATENCY+1 cycles. Misaligned or
//                illegal accesses answer with rsp_error and touch no memory.
//  Ports       : clk, rst (sync, active-low)
//                req_valid/req_ready/req_write/req_addr/req_wdata/req_funct3
//                  - request channel (inputs sampled only at acceptance)
//                rsp_valid/rsp_ready/rsp_rdata/rsp_error
//                  - response channel (held stable until taken)
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_error
);

  localparam int         C_DEPTH    = 1 << DM_ADDRESS;
  localparam logic [3:0] C_CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                  w_accept;
  logic                  w_enter_resp;

  logic                  r_write;
  logic [DM_ADDRESS-1:0] r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [2:0]            r_funct3;
  logic [3:0]            r_cnt;
  logic [DATA_W-1:0]     r_rdata;
  logic                  r_error;

  logic [7:0]            mem [0:C_DEPTH-1];

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    w_accept     = 1'b0;
    w_enter_resp = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept = 1'b1;
          if (LATENCY == 0) begin
            w_state_nxt  = RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt  = RESP;
          w_enter_resp = 1'b1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Access fields: with LATENCY=0 the response is entered on the accepting
  // edge, so the live request inputs must feed decode directly. In every
  // other case the captured copy is used.
  // --------------------------------------------------------------------------
  logic                  w_acc_write;
  logic [DM_ADDRESS-1:0] w_acc_addr;
  logic [DATA_W-1:0]     w_acc_wdata;
  logic [2:0]            w_acc_funct3;

  assign w_acc_write  = (r_state == IDLE) ? req_write  : r_write;
  assign w_acc_addr   = (r_state == IDLE) ? req_addr   : r_addr;
  assign w_acc_wdata  = (r_state == IDLE) ? req_wdata  : r_wdata;
  assign w_acc_funct3 = (r_state == IDLE) ? req_funct3 : r_funct3;

  // --------------------------------------------------------------------------
  // Decode: legality and alignment
  // --------------------------------------------------------------------------
  logic [1:0] w_size;
  logic       w_legal;
  logic       w_misaligned;
  logic       w_err;

  always_comb begin
    w_size = w_acc_funct3[1:0];
    if (w_acc_write) begin
      w_legal = (w_acc_funct3 == 3'b000) || (w_acc_funct3 == 3'b001) ||
                (w_acc_funct3 == 3'b010);
    end else begin
      w_legal = (w_acc_funct3 == 3'b000) || (w_acc_funct3 == 3'b001) ||
                (w_acc_funct3 == 3'b010) || (w_acc_funct3 == 3'b100) ||
                (w_acc_funct3 == 3'b101);
    end
    w_misaligned = ((w_size == 2'b01) && w_acc_addr[0]) ||
                   ((w_size == 2'b10) && (w_acc_addr[1:0] != 2'b00));
    w_err = !w_legal || w_misaligned;
  end

  // --------------------------------------------------------------------------
  // Load path: fetch the containing word, then pick and extend the lane
  // --------------------------------------------------------------------------
  logic [DM_ADDRESS-3:0] w_word_base;
  logic [DATA_W-1:0]     w_rword;
  logic [7:0]            w_rbyte;
  logic [15:0]           w_rhalf;
  logic [DATA_W-1:0]     w_load_data;
  logic [DATA_W-1:0]     w_rsp_data;

  assign w_word_base = w_acc_addr[DM_ADDRESS-1:2];
  assign w_rword     = {mem[{w_word_base, 2'd3}], mem[{w_word_base, 2'd2}],
                        mem[{w_word_base, 2'd1}], mem[{w_word_base, 2'd0}]};

  always_comb begin
    case (w_acc_addr[1:0])
      2'd0:    w_rbyte = w_rword[7:0];
      2'd1:    w_rbyte = w_rword[15:8];
      2'd2:    w_rbyte = w_rword[23:16];
      default: w_rbyte = w_rword[31:24];
    endcase
    w_rhalf = w_acc_addr[1] ? w_rword[31:16] : w_rword[15:0];

    case (w_acc_funct3)
      3'b000:  w_load_data = {{24{w_rbyte[7]}}, w_rbyte};
      3'b001:  w_load_data = {{16{w_rhalf[15]}}, w_rhalf};
      3'b010:  w_load_data = w_rword;
      3'b100:  w_load_data = {24'd0, w_rbyte};
      3'b101:  w_load_data = {16'd0, w_rhalf};
      default: w_load_data = '0;
    endcase

    // Stores and faulting accesses always return zero data.
    w_rsp_data = (w_acc_write || w_err) ? '0 : w_load_data;
  end

  // --------------------------------------------------------------------------
  // Store path: replicate the low data into every lane and enable only the
  // lanes addressed by the access
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] w_lane;
  logic [3:0]        w_be;
  logic              w_do_store;

  always_comb begin
    case (w_size)
      2'b00: begin
        w_lane = {4{w_acc_wdata[7:0]}};
        w_be   = 4'b0001 << w_acc_addr[1:0];
      end
      2'b01: begin
        w_lane = {2{w_acc_wdata[15:0]}};
        w_be   = w_acc_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        w_lane = w_acc_wdata;
        w_be   = 4'b1111;
      end
      default: begin
        w_lane = '0;
        w_be   = 4'b0000;
      end
    endcase
  end

  // Commit happens only on the edge that enters RESP, so a reset while the
  // request is still in WAIT leaves memory untouched.
  assign w_do_store = w_enter_resp && w_acc_write && !w_err;

  always_ff @(posedge clk) begin
    if (rst && w_do_store) begin
      for (int k = 0; k < 4; k++) begin
        if (w_be[k]) begin
          mem[{w_word_base, 2'(k)}] <= w_lane[8*k +: 8];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Request capture, wait counter and response registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_funct3 <= 3'b000;
      r_cnt    <= 4'd0;
      r_rdata  <= '0;
      r_error  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write  <= req_write;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_funct3 <= req_funct3;
      end

      if (w_accept && (LATENCY != 0)) begin
        r_cnt <= C_CNT_INIT;
      end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end

      // Response registers change only on RESP entry, which keeps them
      // stable for as long as the consumer applies backpressure.
      if (w_enter_resp) begin
        r_rdata <= w_rsp_data;
        r_error <= w_err;
      end
    end
  end

  assign rsp_rdata = r_rdata;
  assign rsp_error = r_error;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Directed self-checking bench for dmem_responder. One
//                instance runs with LATENCY=2, a second with LATENCY=0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;

  logic        req_valid, req_ready, req_write;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [31:0] rsp_rdata;

  logic        z_req_valid, z_req_ready, z_req_write;
  logic [8:0]  z_req_addr;
  logic [31:0] z_req_wdata;
  logic [2:0]  z_req_funct3;
  logic        z_rsp_valid, z_rsp_ready, z_rsp_error;
  logic [31:0] z_rsp_rdata;

  int checks   = 0;
  int failures = 0;

  dmem_responder #(.DATA_W(32), .DM_ADDRESS(9), .LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
  );

  dmem_responder #(.DATA_W(32), .DM_ADDRESS(9), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_funct3(z_req_funct3),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
    .rsp_rdata(z_rsp_rdata), .rsp_error(z_rsp_error)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at the negedge of the accepting cycle; collects the response.
  task automatic finish_rsp(output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    req_valid  = 1'b0;
    req_addr   = ~req_addr;
    req_wdata  = ~req_wdata;
    req_funct3 = 3'b111;
    req_write  = ~req_write;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_eq("rsp_seen", 32'(rsp_valid), 32'd1);
    rd = rsp_rdata;
    er = rsp_error;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic issue(input logic wr, input logic [8:0] a, input logic [31:0] wd,
                       input logic [2:0] f3);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_funct3 = f3;
    n = 0;
    while (!req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("accepted", 32'(req_ready), 32'd1);
  endtask

  task automatic xact(input logic wr, input logic [8:0] a, input logic [31:0] wd,
                      input logic [2:0] f3, output logic [31:0] rd, output logic er,
                      output int lat);
    issue(wr, a, wd, f3);
    finish_rsp(rd, er, lat);
  endtask

  task automatic z_xact(input logic wr, input logic [8:0] a, input logic [31:0] wd,
                        input logic [2:0] f3, output logic [31:0] rd, output logic er,
                        output int lat);
    int n;
    @(negedge clk);
    z_req_valid = 1'b1; z_req_write = wr; z_req_addr = a; z_req_wdata = wd; z_req_funct3 = f3;
    n = 0;
    while (!z_req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("z_accepted", 32'(z_req_ready), 32'd1);
    @(negedge clk);
    z_req_valid = 1'b0;
    z_req_addr  = ~z_req_addr;
    lat = 1;
    while (!z_rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_eq("z_rsp_seen", 32'(z_rsp_valid), 32'd1);
    rd = z_rsp_rdata;
    er = z_rsp_error;
    z_rsp_ready = 1'b1;
    @(negedge clk);
    z_rsp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;

    rst = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_funct3 = '0;
    rsp_ready = 1'b0;
    z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_req_funct3 = '0;
    z_rsp_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
    check_eq("rst_rsp_error", 32'(rsp_error), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("post_rst_ready", 32'(req_ready), 32'd1);

    // Word round trip with latency measurement
    xact(1'b1, 9'h010, 32'hDEADBEEF, F_W, rd, er, lat);
    check_eq("sw_err", 32'(er), 32'd0);
    check_eq("sw_rdata", rd, 32'd0);
    check_eq("sw_lat", 32'(lat), 32'd3);
    xact(1'b0, 9'h010, 32'h0, F_W, rd, er, lat);
    check_eq("lw_rdata", rd, 32'hDEADBEEF);
    check_eq("lw_err", 32'(er), 32'd0);
    check_eq("lw_lat", 32'(lat), 32'd3);

    // Sub-word extension
    xact(1'b1, 9'h020, 32'h80FF7F01, F_W, rd, er, lat);
    xact(1'b0, 9'h020, 32'h0, F_B, rd, er, lat);
    check_eq("lb_020", rd, 32'h00000001);
    xact(1'b0, 9'h023, 32'h0, F_B, rd, er, lat);
    check_eq("lb_023", rd, 32'hFFFFFF80);
    xact(1'b0, 9'h023, 32'h0, F_BU, rd, er, lat);
    check_eq("lbu_023", rd, 32'h00000080);
    xact(1'b0, 9'h022, 32'h0, F_H, rd, er, lat);
    check_eq("lh_022", rd, 32'hFFFF80FF);
    xact(1'b0, 9'h022, 32'h0, F_HU, rd, er, lat);
    check_eq("lhu_022", rd, 32'h000080FF);

    // Partial stores use only the low data bytes
    xact(1'b1, 9'h030, 32'h11223344, F_W, rd, er, lat);
    xact(1'b1, 9'h031, 32'h123456AA, F_B, rd, er, lat);
    check_eq("sb_err", 32'(er), 32'd0);
    xact(1'b1, 9'h032, 32'hCAFEBEEF, F_H, rd, er, lat);
    check_eq("sh_err", 32'(er), 32'd0);
    xact(1'b0, 9'h030, 32'h0, F_W, rd, er, lat);
    check_eq("lw_030", rd, 32'hBEEFAA44);

    // Errors
    xact(1'b0, 9'h013, 32'h0, F_W, rd, er, lat);
    check_eq("lw_mis_err", 32'(er), 32'd1);
    check_eq("lw_mis_rdata", rd, 32'd0);
    xact(1'b1, 9'h011, 32'h0000FFFF, F_H, rd, er, lat);
    check_eq("sh_mis_err", 32'(er), 32'd1);
    xact(1'b1, 9'h010, 32'h00000055, F_BU, rd, er, lat);
    check_eq("st_f3_err", 32'(er), 32'd1);
    xact(1'b0, 9'h010, 32'h0, F_W, rd, er, lat);
    check_eq("lw_010_kept", rd, 32'hDEADBEEF);
    xact(1'b0, 9'h014, 32'h0, 3'b011, rd, er, lat);
    check_eq("ld_f3_err", 32'(er), 32'd1);
    check_eq("ld_f3_rdata", rd, 32'd0);

    // Backpressure: second request held on req_valid throughout
    issue(1'b0, 9'h020, 32'h0, F_W);
    @(negedge clk);
    req_addr = 9'h030;
    n = 1;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("bp_lat", 32'(n), 32'd3);
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_valid", 32'(rsp_valid), 32'd1);
      check_eq("bp_data", rsp_rdata, 32'h80FF7F01);
      check_eq("bp_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("bp_ready_back", 32'(req_ready), 32'd1);
    check_eq("bp_valid_low", 32'(rsp_valid), 32'd0);
    finish_rsp(rd, er, lat);
    check_eq("bp_second", rd, 32'hBEEFAA44);
    check_eq("bp_second_lat", 32'(lat), 32'd3);

    // Reset while a store is waiting
    xact(1'b1, 9'h040, 32'h00000000, F_W, rd, er, lat);
    xact(1'b0, 9'h010, 32'h0, F_W, rd, er, lat);
    issue(1'b1, 9'h040, 32'h12345678, F_W);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_eq("mid_rst_ready", 32'(req_ready), 32'd1);
    check_eq("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check_eq("mid_rst_rdata", rsp_rdata, 32'd0);
    check_eq("mid_rst_error", 32'(rsp_error), 32'd0);
    xact(1'b0, 9'h040, 32'h0, F_W, rd, er, lat);
    check_eq("lw_040_nocommit", rd, 32'd0);

    // LATENCY=0 instance
    z_xact(1'b1, 9'h004, 32'hA5A50F0F, F_W, rd, er, lat);
    check_eq("z_sw_lat", 32'(lat), 32'd1);
    z_xact(1'b0, 9'h004, 32'h0, F_W, rd, er, lat);
    check_eq("z_lw_rdata", rd, 32'hA5A50F0F);
    check_eq("z_lw_lat", 32'(lat), 32'd1);
    z_xact(1'b0, 9'h006, 32'h0, F_H, rd, er, lat);
    check_eq("z_lh_rdata", rd, 32'hFFFFA5A5);
    z_xact(1'b0, 9'h005, 32'h0, F_H, rd, er, lat);
    check_eq("z_lh_mis_err", 32'(er), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
